serial_command_decoder: RTL and testbench

//  Consumer of the serial RX package queue. Pops one 4-word package at a time and checks its XOR checksum.

---
 rtl/serial_command_decoder.sv | 133 +++++++++++++
 tb/tb_serial_command_decoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_command_decoder.sv
// Pops 4-word packages from the RX queue, verifies the XOR checksum and turns
// WRITE/READ commands into register-bus strobes or a read/response handshake.
module serial_command_decoder #(
    parameter int         WordWidth     = 8,
    parameter int         ErrCountWidth = 8,
    parameter logic [7:0] OpWrite       = 8'h57,
    parameter logic [7:0] OpRead        = 8'h52
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4*WordWidth-1:0]   pkg,
    input  logic                     pkg_void,
    output logic                     pull,
    output logic                     wr_en,
    output logic [WordWidth-1:0]     wr_addr,
    output logic [WordWidth-1:0]     wr_data,
    output logic                     rd_req,
    output logic [WordWidth-1:0]     rd_addr,
    input  logic                     rd_ack,
    input  logic [WordWidth-1:0]     rd_data,
    output logic                     resp_valid,
    output logic [4*WordWidth-1:0]   resp,
    input  logic                     resp_ready,
    output logic [ErrCountWidth-1:0] err_count,
    output logic                     busy
);

    localparam int W = WordWidth;
    localparam logic [W-1:0] OP_WR = W'(OpWrite);
    localparam logic [W-1:0] OP_RD = W'(OpRead);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t state;

    logic [4*W-1:0] pkg_p0;
    logic [W-1:0]   w0, w1, w2, w3;

    function automatic logic [W-1:0] xor3(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        return a ^ b ^ c;
    endfunction

    function automatic logic [ErrCountWidth-1:0] sat_inc(input logic [ErrCountWidth-1:0] x);
        return (&x) ? x : x + ErrCountWidth'(1);
    endfunction

    assign w0 = pkg_p0[4*W-1:3*W];
    assign w1 = pkg_p0[3*W-1:2*W];
    assign w2 = pkg_p0[2*W-1:W];
    assign w3 = pkg_p0[W-1:0];

    // The pop must coincide with the latch edge, so pull is a decode of the
    // registered state; it is gated by rst so a held reset never drains the queue.
    assign pull = rst && (state == IDLE) && !pkg_void;
    assign busy = (state != IDLE);

    // Stage p0: package capture in the pop cycle (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (state == IDLE && !pkg_void) begin
            pkg_p0 <= pkg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            resp_valid <= 1'b0;
            resp       <= '0;
            err_count  <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (!pkg_void) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (xor3(w0, w1, w2) != w3) begin
                        err_count <= sat_inc(err_count);
                        state     <= IDLE;
                    end else if (w0 == OP_WR) begin
                        wr_en   <= 1'b1;
                        wr_addr <= w1;
                        wr_data <= w2;
                        state   <= WRITE;
                    end else if (w0 == OP_RD) begin
                        rd_req  <= 1'b1;
                        rd_addr <= w1;
                        state   <= READ;
                    end else begin
                        err_count <= sat_inc(err_count);
                        state     <= IDLE;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                READ: begin
                    if (rd_ack) begin
                        rd_req     <= 1'b0;
                        resp       <= {OP_RD, w1, rd_data, xor3(OP_RD, w1, rd_data)};
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_command_decoder.sv
// Directed bench for serial_command_decoder: queue model, write/response scoreboards,
// timing checks and a 2-bit error-counter instance for saturation.
module tb_serial_command_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pkg;
    logic        pkg_void;
    logic        pull, wr_en, rd_req, resp_valid, busy, rd_ack, resp_ready;
    logic [7:0]  wr_addr, wr_data, rd_addr, rd_data, err_count;
    logic [31:0] resp;

    logic [31:0] pkg2;
    logic        pkg_void2, pull2, wr_en2, rd_req2, resp_valid2, busy2, rd_ack2, resp_ready2;
    logic [7:0]  wr_addr2, wr_data2, rd_addr2, rd_data2;
    logic [31:0] resp2;
    logic [1:0]  err2;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int last_pull = 0;
    logic pop_pending = 1'b0;

    logic [31:0] pkg_q[$];
    logic [15:0] exp_wr[$];
    logic [31:0] exp_resp[$];
    int          pull_log[$];
    int          wr_log[$];

    always #5 clk = ~clk;

    serial_command_decoder #(.WordWidth(8), .ErrCountWidth(8)) u_dut (
        .clk(clk), .rst(rst), .pkg(pkg), .pkg_void(pkg_void), .pull(pull),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .resp_valid(resp_valid), .resp(resp), .resp_ready(resp_ready),
        .err_count(err_count), .busy(busy)
    );

    serial_command_decoder #(.WordWidth(8), .ErrCountWidth(2)) u_dut2 (
        .clk(clk), .rst(rst), .pkg(pkg2), .pkg_void(pkg_void2), .pull(pull2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .rd_req(rd_req2), .rd_addr(rd_addr2), .rd_ack(rd_ack2), .rd_data(rd_data2),
        .resp_valid(resp_valid2), .resp(resp2), .resp_ready(resp_ready2),
        .err_count(err2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void refresh();
        pkg_void = (pkg_q.size() == 0);
        pkg      = (pkg_q.size() != 0) ? pkg_q[0] : 32'h0;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_pkg(input logic [7:0] op, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] c);
        pkg_q.push_back({op, a, d, c});
        refresh();
    endtask

    task automatic wait_rdreq();
        for (int i = 0; i < 20 && rd_req !== 1'b1; i++) cyc(1);
        chk("rd_req_seen", rd_req, 1);
    endtask

    // Queue model: the head leaves the queue just after the edge that popped it
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pop_pending) begin
                if (pkg_q.size() != 0) void'(pkg_q.pop_front());
                pop_pending = 1'b0;
            end
            refresh();
        end
    end

    // Output monitor, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cyc_n++;
            if (pull === 1'b1) begin
                chk("pull_while_busy", busy, 0);
                chk("pull_while_void", pkg_void, 0);
                pop_pending = 1'b1;
                last_pull   = cyc_n;
                pull_log.push_back(cyc_n);
            end
            if (wr_en === 1'b1) begin
                wr_log.push_back(cyc_n);
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", wr_en, 0);
                end else begin
                    logic [15:0] e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", wr_addr, e[15:8]);
                    chk("wr_data", wr_data, e[7:0]);
                    chk("wr_latency", cyc_n - last_pull, 2);
                end
            end
            if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
                if (exp_resp.size() == 0) begin
                    chk("resp_unexpected", resp_valid, 0);
                end else begin
                    chk("resp_xfer", resp, exp_resp.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rd_ack = 1'b0; rd_data = 8'h00; resp_ready = 1'b0;
        rd_ack2 = 1'b0; rd_data2 = 8'h00; resp_ready2 = 1'b0;
        pkg2 = 32'h5703A500; pkg_void2 = 1'b1;
        refresh();
        cyc(3);
        chk("rst_pull", pull, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_resp", resp, 0);
        chk("rst_err", err_count, 0);
        rst = 1'b1;
        cyc(1);

        // Single valid write
        exp_wr.push_back(16'h03A5);
        push_pkg(8'h57, 8'h03, 8'hA5, 8'hF1);
        cyc(6);
        chk("t1_wr_drained", exp_wr.size(), 0);
        chk("t1_err", err_count, 0);
        chk("t1_wr_addr_hold", wr_addr, 8'h03);
        chk("t1_busy", busy, 0);

        // Bad checksum, then unknown opcode with a good checksum
        push_pkg(8'h57, 8'h03, 8'hA5, 8'h00);
        cyc(5);
        chk("t2_err_cs", err_count, 1);
        chk("t2_queue_popped", pkg_q.size(), 0);
        push_pkg(8'h41, 8'h01, 8'h02, 8'h42);
        cyc(5);
        chk("t2_err_op", err_count, 2);

        // Read with delayed ack and delayed response acceptance
        push_pkg(8'h52, 8'h07, 8'h00, 8'h55);
        wait_rdreq();
        for (int i = 0; i < 5; i++) begin
            chk("t3_rd_req_hold", rd_req, 1);
            chk("t3_rd_addr", rd_addr, 8'h07);
            cyc(1);
        end
        rd_ack = 1'b1; rd_data = 8'h3C;
        exp_resp.push_back(32'h52073C69);
        cyc(1);
        rd_ack = 1'b0; rd_data = 8'h00;
        chk("t3_rd_req_drop", rd_req, 0);
        chk("t3_resp_valid", resp_valid, 1);
        chk("t3_resp", resp, 32'h52073C69);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("t3_resp_valid_hold", resp_valid, 1);
            chk("t3_resp_stable", resp, 32'h52073C69);
        end
        resp_ready = 1'b1;
        cyc(1);
        resp_ready = 1'b0;
        chk("t3_resp_valid_drop", resp_valid, 0);
        chk("t3_busy", busy, 0);
        chk("t3_resp_drained", exp_resp.size(), 0);

        // Three back-to-back writes
        pull_log.delete();
        wr_log.delete();
        exp_wr.push_back(16'h1011);
        exp_wr.push_back(16'h2022);
        exp_wr.push_back(16'h3033);
        push_pkg(8'h57, 8'h10, 8'h11, 8'h56);
        push_pkg(8'h57, 8'h20, 8'h22, 8'h55);
        push_pkg(8'h57, 8'h30, 8'h33, 8'h54);
        cyc(15);
        chk("t4_pulls", pull_log.size(), 3);
        chk("t4_wrs", wr_log.size(), 3);
        if (pull_log.size() == 3 && wr_log.size() == 3) begin
            chk("t4_pull_gap1", pull_log[1] - pull_log[0], 3);
            chk("t4_pull_gap2", pull_log[2] - pull_log[1], 3);
            chk("t4_wr_gap1", wr_log[1] - wr_log[0], 3);
            chk("t4_wr_gap2", wr_log[2] - wr_log[1], 3);
        end
        chk("t4_wr_drained", exp_wr.size(), 0);

        // Reset in the middle of a read
        exp_wr.push_back(16'h4455);
        push_pkg(8'h52, 8'h0A, 8'h00, 8'h58);
        push_pkg(8'h57, 8'h44, 8'h55, 8'h46);
        wait_rdreq();
        rst = 1'b0;
        cyc(1);
        chk("t5_rd_req", rd_req, 0);
        chk("t5_busy", busy, 0);
        chk("t5_err", err_count, 0);
        chk("t5_rd_addr", rd_addr, 0);
        chk("t5_pull_gated", pull, 0);
        cyc(2);
        chk("t5_queue_kept", pkg_q.size(), 1);
        rst = 1'b1;
        cyc(8);
        chk("t5_wr_drained", exp_wr.size(), 0);
        chk("t5_wr_addr", wr_addr, 8'h44);
        chk("t5_resp_valid", resp_valid, 0);

        // 2-bit error counter saturation
        for (int i = 0; i < 5; i++) begin
            logic [1:0] e;
            e = (i < 3) ? 2'(i + 1) : 2'd3;
            pkg_void2 = 1'b0;
            cyc(1);
            pkg_void2 = 1'b1;
            cyc(2);
            chk("t6_err_sat", err2, e);
        end
        chk("t6_busy2", busy2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
